// File: rtl/wfg_stim_ramp_top.sv
// Ramp / triangle stimulus source: four Wishbone registers configure a counter
// whose values are streamed one per AXI-stream handshake.
`timescale 1ns/1ps
module wfg_stim_ramp_top #(
  parameter int BUSW = 32,
  parameter int DATW = 18
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [BUSW-1:0] wbs_dat_i,
  input  logic [BUSW-1:0] wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [BUSW-1:0] wbs_dat_o,
  input  logic            wfg_axis_tready_i,
  output logic            wfg_axis_tvalid_o,
  output logic [DATW-1:0] wfg_axis_tdata_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [1:0] ADR_CTRL  = 2'd0;
  localparam logic [1:0] ADR_START = 2'd1;
  localparam logic [1:0] ADR_STEP  = 2'd2;
  localparam logic [1:0] ADR_LIMIT = 2'd3;

  logic            access, wr_en, handshake;
  logic [1:0]      reg_sel, state;
  logic            en, mode, dir, tvalid, nxt_dir;
  logic [DATW-1:0] start, step, limit, cur, nxt;
  logic [DATW:0]   sum, lo_bound, cur_x, limit_x;
  logic [BUSW-1:0] rdata;
  logic            unused_bits;

  // The ack term blocks a new access in the cycle after an ack.
  assign access    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_en     = access & wbs_we_i;
  assign reg_sel   = wbs_adr_i[3:2];
  assign handshake = tvalid & wfg_axis_tready_i;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[BUSW-1:4], wbs_adr_i[1:0],
                         wbs_dat_i[BUSW-1:DATW]};

  assign wfg_axis_tvalid_o = tvalid;
  assign wfg_axis_tdata_o  = cur;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    rdata = '0;
    case (reg_sel)
      ADR_CTRL:  rdata[2:0]      = {dir, mode, en};
      ADR_START: rdata[DATW-1:0] = start;
      ADR_STEP:  rdata[DATW-1:0] = step;
      ADR_LIMIT: rdata[DATW-1:0] = limit;
    endcase
  end

  // Sums carry one extra bit so a ramp ending at the full-scale code still wraps.
  assign cur_x    = {1'b0, cur};
  assign limit_x  = {1'b0, limit};
  assign sum      = cur_x + {1'b0, step};
  assign lo_bound = {1'b0, start} + {1'b0, step};

  always_comb begin
    nxt     = cur;
    nxt_dir = dir;
    if (start >= limit) begin
      nxt     = start;
      nxt_dir = 1'b0;
    end else if (!mode) begin
      nxt = (sum > limit_x) ? start : sum[DATW-1:0];
    end else if (!dir) begin
      if (sum > limit_x) begin
        nxt_dir = 1'b1;
        nxt     = (cur_x >= lo_bound) ? cur - step : start;
      end else begin
        nxt = sum[DATW-1:0];
      end
    end else begin
      if (cur_x < lo_bound) begin
        nxt_dir = 1'b0;
        nxt     = (sum > limit_x) ? limit : sum[DATW-1:0];
      end else begin
        nxt = cur - step;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en    <= 1'b0;
      mode  <= 1'b0;
      start <= '0;
      step  <= DATW'(1);
      limit <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        ADR_CTRL: begin
          en   <= wbs_dat_i[0];
          mode <= wbs_dat_i[1];
        end
        ADR_START: start <= wbs_dat_i[DATW-1:0];
        ADR_STEP:  step  <= wbs_dat_i[DATW-1:0];
        ADR_LIMIT: limit <= wbs_dat_i[DATW-1:0];
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      tvalid <= 1'b0;
      cur    <= '0;
      dir    <= 1'b0;
    end else begin
      if (handshake) begin
        cur <= nxt;
        dir <= nxt_dir;
      end
      case (state)
        IDLE: if (en) begin
          cur    <= start;
          dir    <= 1'b0;
          tvalid <= 1'b1;
          state  <= RUN;
        end
        RUN: if (!en) begin
          if (wfg_axis_tready_i) begin
            tvalid <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: if (wfg_axis_tready_i) begin
          tvalid <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          tvalid <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wfg_stim_ramp_top.sv
// Scoreboard bench for wfg_stim_ramp_top: a sequence model fills the expected
// queue per run, and a negedge monitor checks every beat and every stall.
`timescale 1ns/1ps
module tb_wfg_stim_ramp_top;
  localparam int BUSW = 32;
  localparam int DATW = 18;

  logic            clk = 1'b0;
  logic            rst;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [BUSW-1:0] dat_w, adr;
  logic            ack;
  logic [BUSW-1:0] dat_r;
  logic            tready, tvalid;
  logic [DATW-1:0] tdata;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_beats = 0;

  logic [DATW-1:0] exp_q[$];

  int unsigned cfg_s, cfg_st, cfg_l;
  bit          cfg_tri;

  always #5 clk = ~clk;

  wfg_stim_ramp_top #(.BUSW(BUSW), .DATW(DATW)) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst),
    .wbs_stb_i        (stb),
    .wbs_cyc_i        (cyc),
    .wbs_we_i         (we),
    .wbs_sel_i        (sel),
    .wbs_dat_i        (dat_w),
    .wbs_adr_i        (adr),
    .wbs_ack_o        (ack),
    .wbs_dat_o        (dat_r),
    .wfg_axis_tready_i(tready),
    .wfg_axis_tvalid_o(tvalid),
    .wfg_axis_tdata_o (tdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ramp values sit on the grid START + k*STEP; saw cycles indices 0..m,
  // triangle bounces 0..m..1 with period 2m.
  function automatic void push_expected(input int unsigned s, input int unsigned st,
                                        input int unsigned l, input bit tri_mode, input int n);
    int unsigned m, p, idx;
    m = (st == 0 || s >= l) ? 0 : (l - s) / st;
    for (int k = 0; k < n; k++) begin
      if (m == 0) idx = 0;
      else if (tri_mode) begin
        p   = k % (2 * m);
        idx = (p <= m) ? p : 2 * m - p;
      end else idx = k % (m + 1);
      exp_q.push_back(DATW'(s + idx * st));
    end
  endfunction

  // Monitor: every handshake pops one expected sample; a stalled beat must hold.
  logic            prev_stall = 1'b0;
  logic [DATW-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", 32'(tvalid), 32'd1);
        check("stall_tdata", 32'(tdata), 32'(prev_data));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got tdata %0d, expected no beat (t=%0t)", tdata, $time);
        end else begin
          check("beat", 32'(tdata), 32'(exp_q.pop_front()));
        end
        n_beats++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
    end
  end

  task automatic wb_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic tv_at_ack);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = wr; adr = a; dat_w = d;
    @(posedge clk); #1;
    check("ack_rise", 32'(ack), 32'd1);
    rd        = dat_r;
    tv_at_ack = tvalid;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_width", 32'(ack), 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        tv;
    wb_access(1'b1, a, d, rd, tv);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    logic tv;
    wb_access(1'b0, a, 32'd0, rd, tv);
  endtask

  task automatic cfg(input int unsigned s, input int unsigned st, input int unsigned l, input bit t);
    cfg_s = s; cfg_st = st; cfg_l = l; cfg_tri = t;
    wb_write(32'h4, s);
    wb_write(32'h8, st);
    wb_write(32'hC, l);
  endtask

  task automatic enable();
    logic [31:0] rd;
    logic        tv;
    exp_q.delete();
    push_expected(cfg_s, cfg_st, cfg_l, cfg_tri, 2000);
    wb_access(1'b1, 32'h0, {30'd0, cfg_tri, 1'b1}, rd, tv);
    check("tvalid_at_ack", 32'(tv), 32'd0);
    check("tvalid_rise", 32'(tvalid), 32'd1);
    check("first_sample", 32'(tdata), cfg_s);
  endtask

  task automatic disable_run(input bit rand_rdy);
    int cyc_n;
    wb_write(32'h0, {30'd0, cfg_tri, 1'b0});
    cyc_n = 0;
    while (tvalid && cyc_n < 200) begin
      if (rand_rdy) tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc_n++;
    end
    if (tvalid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: tvalid still 1 after %0d cycles", cyc_n);
    end
    exp_q.delete();
  endtask

  task automatic run_beats(input int target);
    int base, cyc_n;
    base  = n_beats;
    cyc_n = 0;
    while (n_beats - base < target && cyc_n < 20 * target) begin
      tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc_n++;
    end
    check("beats_delivered", 32'(n_beats - base >= target), 32'd1);
  endtask

  task automatic check_reset_regs();
    logic [31:0] rd;
    wb_read(32'h0, rd); check("ctrl_reset", rd, 32'd0);
    wb_read(32'h4, rd); check("start_reset", rd, 32'd0);
    wb_read(32'h8, rd); check("step_reset", rd, 32'd1);
    wb_read(32'hC, rd); check("limit_reset", rd, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int unsigned s, st, l;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
    dat_w = '0; adr = '0; tready = 1'b0;
    #12;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dat_r, 32'd0);
    @(negedge clk) rst = 1'b0;
    check_reset_regs();

    // Sawtooth 2,5,8 at full throughput
    cfg(2, 3, 10, 1'b0);
    tready = 1'b1;
    enable();
    repeat (20) @(posedge clk);
    disable_run(1'b0);

    // Triangle 2,5,8,5,2,...: freeze mid-descent and mid-ascent to read DIR
    cfg(2, 3, 10, 1'b1);
    tready = 1'b0;
    enable();
    tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 tready = 1'b0;
    wb_read(32'h0, rd); check("ctrl_dir_down", rd, 32'd7);
    tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 tready = 1'b0;
    wb_read(32'h0, rd); check("ctrl_dir_up", rd, 32'd3);
    tready = 1'b1;
    repeat (20) @(posedge clk);
    disable_run(1'b0);

    // EN cleared while a beat is stalled: beat held until accepted, then restart
    cfg(5, 4, 30, 1'b0);
    tready = 1'b1;
    enable();
    repeat (7) @(posedge clk);
    #1 tready = 1'b0;
    wb_write(32'h0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("drain_hold", 32'(tvalid), 32'd1);
    end
    tready = 1'b1;
    @(posedge clk); #1;
    check("drain_drop", 32'(tvalid), 32'd0);
    exp_q.delete();
    enable();
    repeat (10) @(posedge clk);
    disable_run(1'b0);

    // START >= LIMIT: constant START, DIR stays up
    cfg(7, 2, 3, 1'b1);
    tready = 1'b1;
    enable();
    repeat (10) @(posedge clk);
    wb_read(32'h0, rd); check("ctrl_const_dir", rd, 32'd3);
    disable_run(1'b0);

    // STEP = 0: constant output
    cfg(4, 0, 9, 1'b0);
    enable();
    repeat (10) @(posedge clk);
    disable_run(1'b0);

    // Randomised configurations under random backpressure, 1000 beats total
    for (int c = 0; c < 4; c++) begin
      s  = $urandom_range(0, 2000);
      st = $urandom_range(1, 60);
      l  = s + st * $urandom_range(1, 12) + $urandom_range(0, st - 1);
      cfg(s, st, l, 1'($urandom_range(0, 1)));
      tready = 1'b0;
      enable();
      run_beats(250);
      disable_run(1'b1);
    end

    // Full-scale LIMIT, then async reset mid-stream
    cfg(262140, 2, 262143, 1'b0);
    tready = 1'b1;
    enable();
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_tvalid", 32'(tvalid), 32'd0);
    check("async_rst_tdata", 32'(tdata), 32'd0);
    exp_q.delete();
    tready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
